hilo_muldiv: RTL
================

HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width (even, 8..64); HI and LO are each WIDTH bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled only when ready=1.
REQ-005 The block SHALL have port op, input, 2 bits: operation select, 00 MULTU, 01 DIVU, 10 MULT, 11 DIV; captured with start.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: multiplicand/dividend (a) and multiplier/divisor (b); captured with start.
REQ-007 The block SHALL have port cancel, input, 1 bit: abort an operation in progress.
REQ-008 The block SHALL have ports hi_we and lo_we, input, 1 bit each, plus wdata, input, WIDTH bits: direct MTHI/MTLO writes.
REQ-009 The block SHALL have output ports ready, busy and done, 1 bit each: idle-accepting, computing, and a one-cycle result-valid pulse.
REQ-010 The block SHALL have output ports hi and lo, WIDTH bits each: registered HI/LO, read directly for MFHI/MFLO.
REQ-011 The block SHALL have output port div_by_zero, 1 bit: valid together with done.

Function
REQ-012 The FSM SHALL have three states: IDLE (ready=1), CALC (busy=1) and DONE (done=1); exactly one of ready, busy and done is high in any cycle.
REQ-013 IDLE with start=1 SHALL go to CALC: latch op, a and b, load the iteration counter with WIDTH (counter width clog2(WIDTH+1)).
REQ-014 CALC SHALL perform one iteration per cycle, then decrement the counter; when the counter reaches 1 and the last iteration completes, the FSM SHALL go to DONE.
REQ-015 Multiply SHALL be shift-add, one multiplier bit per cycle, giving a 2*WIDTH product: hi = upper half, lo = lower half.
REQ-016 Divide SHALL be restoring, one quotient bit per cycle: lo = quotient, hi = remainder.
REQ-017 hi, lo and div_by_zero SHALL update on the edge entering DONE; done SHALL be high for exactly one cycle, WIDTH+1 cycles after the start edge; DONE SHALL then go to IDLE unconditionally.
REQ-018 start SHALL be ignored in CALC and DONE; there is no queueing.
REQ-019 Divide by zero (b=0) SHALL run the full latency and give lo = all ones, hi = a, div_by_zero=1.
REQ-020 div_by_zero SHALL be 0 for every other result and SHALL hold its value until the next done.
REQ-021 Signed ops SHALL operate on magnitudes and apply the sign in the DONE transition.
REQ-022 Signed quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-023 For DIV with the most-negative dividend and divisor -1, the result SHALL be lo = most-negative value, hi = 0.
REQ-024 cancel=1 in CALC SHALL return to IDLE next edge, with no done, hi and lo unchanged, and div_by_zero unchanged.
REQ-025 cancel SHALL be ignored in IDLE and DONE.
REQ-026 hi_we and lo_we SHALL write wdata to hi and/or lo only in IDLE, and SHALL be ignored in CALC and DONE.
REQ-027 A write together with start in IDLE SHALL be performed; the later result then overwrites it.

Reset
REQ-028 Asserting rst_n=0 in any state, including mid-CALC, SHALL immediately force IDLE and clear the counter and internal operands.
REQ-029 While rst_n=0, outputs SHALL be: ready=1, busy=0, done=0, hi=0, lo=0, div_by_zero=0.
REQ-030 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-031 With macro MULDIV_SIGNED_EN defined, op[1]=1 SHALL select the signed MULT/DIV behaviour of REQ-021 to REQ-023.
REQ-032 With MULDIV_SIGNED_EN undefined, op[1] SHALL be ignored, all ops SHALL be unsigned (10 behaves as 00, 11 as 01), and no sign-correction logic is built.

Verification (WIDTH=32)
REQ-033 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done exactly 33 cycles after the start edge, hi=0xFFFFFFFE, lo=0x00000001, busy high for 32 cycles.
REQ-034 DIVU a=100 b=7 -> lo=14, hi=2, div_by_zero=0; DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1.
REQ-035 MULDIV_SIGNED_EN on: MULT a=-3 b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV a=0xFFFFFFF9 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 MULDIV_SIGNED_EN off: op=10 a=-3 b=5 -> hi=0x00000004, lo=0xFFFFFFF1 (unsigned product).
REQ-037 Cancel 10 cycles after start, with prior hi=0xAAAA and lo=0x5555 -> no done pulse, ready next cycle, hi and lo unchanged; start during CALC/DONE and hi_we in CALC -> no effect.
REQ-038 rst_n low mid-CALC -> outputs take reset values immediately with no clock; after release, a new DIVU 100/7 completes correctly.

Source files
------------

// File: rtl/hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv
// Description : Iterative HI/LO multiply/divide unit. Shift-add multiply and
//               restoring divide, one bit per cycle, WIDTH cycles per op.
//               Results land in registered HI/LO on the edge entering DONE.
//               Optional macro MULDIV_SIGNED_EN enables signed MULT/DIV
//               (op[1]=1); without it op[1] is ignored and all ops are
//               unsigned.
// Ports       : clk, rst_n (async, active-low)
//               start/op/a/b : launch an operation (sampled when ready)
//               cancel       : abort a running operation
//               hi_we/lo_we/wdata : direct HI/LO writes while idle
//               ready/busy/done   : one-hot status (IDLE/CALC/DONE)
//               hi/lo/div_by_zero : registered results
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int C_CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [C_CNT_W-1:0]   r_cnt;
    logic                 r_is_div;
    logic                 r_dz;         // b==0 seen at start of a divide
    logic [WIDTH-1:0]     r_m;          // multiplicand (mul) or divisor (div)
    logic [2*WIDTH-1:0]   r_acc;        // {upper, lower} working register
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_dz_out;

    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_rem_sh;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_rem_sub;
    logic [WIDTH-1:0]     w_rem_new;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_iter;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;

`ifdef MULDIV_SIGNED_EN
    logic                 r_neg_q;      // negate product / quotient
    logic                 r_neg_r;      // negate remainder (dividend sign)
    logic                 w_signed;
    logic [2*WIDTH-1:0]   w_prod_fix;

    assign w_signed = op[1];
    // Signed ops run on magnitudes; the sign is reapplied when entering DONE.
    assign w_a_mag  = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_b_mag  = (w_signed && b[WIDTH-1]) ? -b : b;
`else
    logic                 w_unused_op1;

    assign w_unused_op1 = op[1];
    assign w_a_mag      = a;
    assign w_b_mag      = b;
`endif

    // Shift-add multiply: conditionally add the multiplicand into the upper
    // half, then shift the whole register right, carry included.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. The shifted remainder needs one
    // extra bit, but the difference always fits back into WIDTH bits.
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge       = (w_rem_sh >= {1'b0, r_m});
    assign w_rem_sub  = w_rem_sh[WIDTH-1:0] - r_m;
    assign w_rem_new  = w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
    assign w_div_next = {w_rem_new, r_acc[WIDTH-2:0], w_ge};

    assign w_iter     = r_is_div ? w_div_next : w_mul_next;

    // Final result from the last iteration, with sign fix-up where enabled.
    always_comb begin
        w_res_hi = w_iter[2*WIDTH-1:WIDTH];
        w_res_lo = w_iter[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
        w_prod_fix = r_neg_q ? -w_iter : w_iter;
        if (r_is_div) begin
            w_res_lo = r_neg_q ? -w_iter[WIDTH-1:0] : w_iter[WIDTH-1:0];
            w_res_hi = r_neg_r ? -w_iter[2*WIDTH-1:WIDTH] : w_iter[2*WIDTH-1:WIDTH];
        end else begin
            w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod_fix[WIDTH-1:0];
        end
`endif
        // Divide by zero: the remainder already equals the dividend (its
        // sign restored above), only the quotient is forced to all ones.
        if (r_is_div && r_dz) begin
            w_res_lo = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_m      <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dz_out <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start) begin
                        r_state  <= S_CALC;
                        r_cnt    <= C_CNT_W'(WIDTH);
                        r_is_div <= op[0];
                        r_dz     <= op[0] && (b == '0);
                        r_m      <= op[0] ? w_b_mag : w_a_mag;
                        r_acc    <= {{WIDTH{1'b0}}, (op[0] ? w_a_mag : w_b_mag)};
`ifdef MULDIV_SIGNED_EN
                        r_neg_q  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r  <= w_signed && a[WIDTH-1];
`endif
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_iter;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == C_CNT_W'(1)) begin
                            r_state  <= S_DONE;
                            r_hi     <= w_res_hi;
                            r_lo     <= w_res_lo;
                            r_dz_out <= r_dz;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready       = (r_state == S_IDLE);
    assign busy        = (r_state == S_CALC);
    assign done        = (r_state == S_DONE);
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dz_out;

endmodule
`default_nettype wire
